// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - immediate-source codes and instruction field slices
package ext_pkg;

  typedef enum logic [2:0] {
    IMM_DP8   = 3'b000,
    IMM_MEM12 = 3'b001,
    IMM_BR24  = 3'b010,
    IMM_DPROT = 3'b011,
    IMM_HALF  = 3'b100
  } imm_src_e;

  localparam int FIELD_W     = 24;
  localparam int IMM8_MSB    = 7;
  localparam int MEM12_MSB   = 11;
  localparam int ROT_MSB     = 11;
  localparam int ROT_LSB     = 8;
  localparam int HALF_LO_MSB = 3;
  localparam int BR_SEXT_W   = 26;

  // Rotate right by concatenating the word with itself and keeping the low half.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
    logic [63:0] dbl;
    dbl = {x, x} >> amt;
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/ext_pipe_slice.sv
// rtl/ext_pipe_slice.sv - generic valid/ready register slice
module ext_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Data only moves on an accepted transfer, so unaccepted inputs never reach the outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined ARMv4 immediate generator with valid/ready handshakes
module imm_extend_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        imm_src,
  input  logic [23:0]       instr_field,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_imm,
  output logic              shifter_carry,
  output logic              illegal
);

  localparam int PW = DATA_W + 2;

  logic [DATA_W-1:0] ext_c;
  logic              carry_c;
  logic              illegal_c;
  logic [31:0]       rot_c;
  logic [4:0]        rot_amt;

  always_comb begin
    rot_amt   = {instr_field[ROT_MSB:ROT_LSB], 1'b0};
    rot_c     = ror32({24'b0, instr_field[IMM8_MSB:0]}, rot_amt);
    ext_c     = '0;
    carry_c   = carry_in;
    illegal_c = 1'b0;
    case (imm_src)
      IMM_DP8:   ext_c[IMM8_MSB:0]  = instr_field[IMM8_MSB:0];
      IMM_MEM12: ext_c[MEM12_MSB:0] = instr_field[MEM12_MSB:0];
      IMM_BR24: begin
        ext_c                 = {DATA_W{instr_field[FIELD_W-1]}};
        ext_c[BR_SEXT_W-1:0]  = {instr_field, 2'b00};
      end
      IMM_DPROT: begin
        ext_c[31:0] = rot_c;
        // A zero rotate leaves the CPSR carry untouched.
        if (instr_field[ROT_MSB:ROT_LSB] != 4'd0) carry_c = rot_c[31];
      end
      IMM_HALF:  ext_c[7:0] = {instr_field[ROT_MSB:ROT_LSB], instr_field[HALF_LO_MSB:0]};
      default: begin
        carry_c   = 1'b0;
        illegal_c = 1'b1;
      end
    endcase
  end

  logic [PIPE_STAGES:0][PW-1:0] stage_data;
  logic [PIPE_STAGES:0]         stage_valid;
  logic [PIPE_STAGES:0]         stage_ready;

  assign stage_data[0]           = {illegal_c, carry_c, ext_c};
  assign stage_valid[0]          = in_valid;
  assign in_ready                = stage_ready[0];
  assign stage_ready[PIPE_STAGES] = out_ready;

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    ext_pipe_slice #(.W(PW)) u_slice (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (stage_valid[i]),
      .in_ready  (stage_ready[i]),
      .in_data   (stage_data[i]),
      .out_valid (stage_valid[i+1]),
      .out_ready (stage_ready[i+1]),
      .out_data  (stage_data[i+1])
    );
  end

  assign out_valid                        = stage_valid[PIPE_STAGES];
  assign {illegal, shifter_carry, ext_imm} = stage_data[PIPE_STAGES];

endmodule
